// File: rtl/fp_pkg.sv
// fp_pkg: shared FPU widths, IEEE constants, divider state enum and flag vector
package fp_pkg;
  localparam int MANTISSA_SIZE = 52;
  localparam int EXPONENT_SIZE = 11;
  localparam int BIAS = 1023;
  localparam logic [63:0] NAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] INFINITY_P = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] INFINITY_N = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] ZERO = 64'h0;
  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} fp_div_state_t;
  typedef struct packed {
    logic invalid;
    logic divzero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;
  function automatic int fp_mant(int bw);
    return bw == 32 ? 23 : MANTISSA_SIZE;
  endfunction
  function automatic int fp_exp(int bw);
    return bw == 32 ? 8 : EXPONENT_SIZE;
  endfunction
  function automatic int fp_bias(int bw);
    return bw == 32 ? 127 : BIAS;
  endfunction
  function automatic logic [63:0] fp_nan(int bw);
    return bw == 32 ? 64'h7FC0_0000 : NAN;
  endfunction
  function automatic logic [63:0] fp_inf(int bw, logic s);
    return bw == 32 ? {32'b0, s, 8'hFF, 23'b0} : s ? INFINITY_N : INFINITY_P;
  endfunction
endpackage

// File: rtl/fp_div_if.sv
// fp_div_if: start/done handshake and operand/result bus of the FP divider
// master: issue side (drives start/in1/in2); slave: divider (drives busy/done/out[/flags])
// FPDIV_FLAGS_EN adds the flags vector
interface fp_div_if #(parameter int BUS_WIDTH = 64);
  logic start;
  logic [BUS_WIDTH-1:0] in1;
  logic [BUS_WIDTH-1:0] in2;
  logic busy;
  logic done;
  logic [BUS_WIDTH-1:0] out;
`ifdef FPDIV_FLAGS_EN
  import fp_pkg::*;
  fp_flags_t flags;
  modport master (output start, in1, in2, input busy, done, out, flags);
  modport slave (input start, in1, in2, output busy, done, out, flags);
`else
  modport master (output start, in1, in2, input busy, done, out);
  modport slave (input start, in1, in2, output busy, done, out);
`endif
endinterface

// File: rtl/fp_classify.sv
// fp_classify: flags an operand magnitude as zero (denormals flushed), inf or NaN
// mag_i: operand without sign bit; is_zero_o/is_inf_o/is_nan_o: classification
module fp_classify
  import fp_pkg::*;
#(parameter int BUS_WIDTH = 64) (
  input  logic [BUS_WIDTH-2:0] mag_i,
  output logic                 is_zero_o,
  output logic                 is_inf_o,
  output logic                 is_nan_o
);
  localparam int ES = fp_exp(BUS_WIDTH);
  localparam int MS = fp_mant(BUS_WIDTH);
  logic e_max, m_zero;
  assign e_max = &mag_i[BUS_WIDTH-2 -: ES];
  assign m_zero = ~|mag_i[MS-1:0];
  assign is_zero_o = ~|mag_i[BUS_WIDTH-2 -: ES];
  assign is_inf_o = e_max & m_zero;
  assign is_nan_o = e_max & ~m_zero;
endmodule

// File: rtl/fp_div.sv
// fp_div: sequential IEEE-754 divider, one restoring quotient bit per cycle then RNE round
// clk, rst (sync, active-high); bus: fp_div_if.slave with start/in1/in2 in, busy/done/out out
// FPDIV_FLAGS_EN adds bus.flags = {invalid, divzero, overflow, underflow, inexact}
module fp_div
  import fp_pkg::*;
#(parameter int BUS_WIDTH = 64) (
  input logic     clk,
  input logic     rst,
  fp_div_if.slave bus
);
  localparam int MS = fp_mant(BUS_WIDTH);
  localparam int ES = fp_exp(BUS_WIDTH);
  localparam int BI = fp_bias(BUS_WIDTH);
  localparam int N = MS + 3;
  localparam int CW = $clog2(N + 1);
  localparam logic signed [ES+1:0] EMAX = (ES+2)'(2 * BI + 1);
  fp_div_state_t state_q, state_d;
  logic sign_q, sign_d;
  logic signed [ES+1:0] exp_q, exp_d;
  logic [MS+1:0] rem_q, rem_d;
  logic [MS:0] b_q, b_d;
  logic [N-2:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] out_q, out_d;
  logic z1, i1, n1, z2, i2, n2;
  logic sgn, a_lt_b, nan_hit, inf_hit, spec_hit, qbit, g, r, s, inc, carry, ovf, unf;
  logic [MS:0] ma, mb;
  logic [MS+1:0] rem_s;
  logic [MS-1:0] frac_r;
  logic signed [ES+1:0] e1, e2, exp_r;
  logic [BUS_WIDTH-1:0] special, rounded;
  fp_classify #(.BUS_WIDTH(BUS_WIDTH)) u_cls1 (.mag_i(bus.in1[BUS_WIDTH-2:0]), .is_zero_o(z1), .is_inf_o(i1), .is_nan_o(n1));
  fp_classify #(.BUS_WIDTH(BUS_WIDTH)) u_cls2 (.mag_i(bus.in2[BUS_WIDTH-2:0]), .is_zero_o(z2), .is_inf_o(i2), .is_nan_o(n2));
  assign sgn = bus.in1[BUS_WIDTH-1] ^ bus.in2[BUS_WIDTH-1];
  assign ma = {1'b1, bus.in1[MS-1:0]};
  assign mb = {1'b1, bus.in2[MS-1:0]};
  assign a_lt_b = ma < mb;
  assign e1 = {2'b00, bus.in1[BUS_WIDTH-2 -: ES]};
  assign e2 = {2'b00, bus.in2[BUS_WIDTH-2 -: ES]};
  // priority: NaN, then x/0 and inf/x give inf, anything left is +0
  assign nan_hit = n1 | n2 | (i1 & i2) | (z1 & z2);
  assign inf_hit = z2 | i1;
  assign spec_hit = nan_hit | inf_hit | z1 | i2;
  assign special = nan_hit ? BUS_WIDTH'(fp_nan(BUS_WIDTH)) : inf_hit ? BUS_WIDTH'(fp_inf(BUS_WIDTH, sgn)) : BUS_WIDTH'(ZERO);
  assign qbit = rem_q >= {1'b0, b_q};
  assign rem_s = qbit ? rem_q - {1'b0, b_q} : rem_q;
  // integer bit is always 1 and is not kept; quo_q = {fraction, G, R}
  assign g = quo_q[1];
  assign r = quo_q[0];
  assign s = |rem_q;
  assign inc = g & (quo_q[2] | r | s);
  assign {carry, frac_r} = {1'b0, quo_q[N-2:2]} + (MS+1)'(inc);
  assign exp_r = exp_q + $signed({{(ES+1){1'b0}}, carry});
  assign unf = exp_r[ES+1] | ~|exp_r;
  assign ovf = ~exp_r[ES+1] & (exp_r >= EMAX);
  assign rounded = ovf ? BUS_WIDTH'(fp_inf(BUS_WIDTH, sign_q)) : unf ? BUS_WIDTH'(ZERO) : {sign_q, exp_r[ES-1:0], frac_r};
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    exp_d = exp_q;
    rem_d = rem_q;
    b_d = b_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    out_d = out_q;
    case (state_q)
      IDLE: if (bus.start) begin
        sign_d = sgn;
        exp_d = e1 - e2 + (ES+2)'(BI) - (ES+2)'(a_lt_b);
        rem_d = a_lt_b ? {ma, 1'b0} : {1'b0, ma};
        b_d = mb;
        quo_d = '0;
        cnt_d = CW'(N);
        out_d = spec_hit ? special : out_q;
        state_d = spec_hit ? DONE : DIV;
      end
      DIV: begin
        quo_d = {quo_q[N-3:0], qbit};
        rem_d = rem_s << 1;
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? ROUND : DIV;
      end
      ROUND: begin
        out_d = rounded;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      exp_q <= '0;
      rem_q <= '0;
      b_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      exp_q <= exp_d;
      rem_q <= rem_d;
      b_q <= b_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.out = out_q;
`ifdef FPDIV_FLAGS_EN
  fp_flags_t flags_q, flags_d;
  always_comb flags_d = (state_q == IDLE && bus.start && spec_hit) ? {nan_hit, ~nan_hit & z2 & ~i1 & ~z1, 3'b000}
                      : state_q == ROUND ? {2'b00, ovf, unf, g | r | s | ovf | unf} : flags_q;
  always_ff @(posedge clk) flags_q <= rst ? '0 : flags_d;
  assign bus.flags = flags_q;
`endif
endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: directed checks of fp_div at 64 and 32 bits
module tb_fp_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fp_div_if #(.BUS_WIDTH(64)) b64 ();
  fp_div_if #(.BUS_WIDTH(32)) b32 ();
  fp_div #(.BUS_WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));
  fp_div #(.BUS_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  int total = 0;
  int bad = 0;
  bit sel32 = 1'b0;
  logic cur_done, cur_busy;
  logic [63:0] cur_out;
  assign cur_done = sel32 ? b32.done : b64.done;
  assign cur_busy = sel32 ? b32.busy : b64.busy;
  assign cur_out = sel32 ? {32'b0, b32.out} : b64.out;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic st, input logic [63:0] a, input logic [63:0] b);
    if (sel32) begin
      b32.start = st;
      b32.in1 = a[31:0];
      b32.in2 = b[31:0];
    end else begin
      b64.start = st;
      b64.in1 = a;
      b64.in2 = b;
    end
  endtask
  task automatic op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp, input int lat);
    int cyc = 1;
    int busy_n = 0;
    @(negedge clk);
    drive(1'b1, a, b);
    @(posedge clk);
    #1 drive(1'b0, a, b);
    while (!cur_done && cyc < 200) begin
      busy_n += int'(cur_busy);
      @(posedge clk);
      #1 cyc++;
    end
    busy_n += int'(cur_busy);
    chk({tag, "_done"}, 64'(cur_done), 64'd1);
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_busy"}, 64'(busy_n), 64'(lat));
    chk({tag, "_out"}, cur_out, exp);
    @(posedge clk);
    #1 chk({tag, "_idle"}, {62'b0, cur_busy, cur_done}, 64'd0);
  endtask
  initial begin
    int dn, first;
    b64.start = 1'b1;
    b64.in1 = 64'h4018000000000000;
    b64.in2 = 64'h4000000000000000;
    b32.start = 1'b0;
    b32.in1 = '0;
    b32.in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy64", 64'(b64.busy), 64'd0);
    chk("rst_done64", 64'(b64.done), 64'd0);
    chk("rst_out64", b64.out, 64'd0);
    chk("rst_busy32", 64'(b32.busy), 64'd0);
    chk("rst_out32", 64'(b32.out), 64'd0);
    @(negedge clk);
    b64.start = 1'b0;
    rst = 1'b0;
    op("div6_2", 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 57);
    op("div1_3", 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 57);
    op("one_zero", 64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 1);
    op("neg_zero", 64'hBFF0000000000000, 64'h0000000000000000, 64'hFFF0000000000000, 1);
    op("zero_zero", 64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 1);
    op("inf_inf", 64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 1);
    op("ovf", 64'h7FE0000000000000, 64'h3FE0000000000000, 64'h7FF0000000000000, 57);
    op("unf", 64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 57);
    // start held through the whole operation, operands changed mid-flight
    @(negedge clk);
    drive(1'b1, 64'h4018000000000000, 64'h4000000000000000);
    dn = 0;
    first = 0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) drive(1'b1, 64'h3FF0000000000000, 64'h4008000000000000);
      if (cur_done) begin
        dn++;
        if (first == 0) first = c;
      end
      if (c == 57) drive(1'b0, 64'h0, 64'h0);
    end
    chk("held_pulses", 64'(dn), 64'd1);
    chk("held_lat", 64'(first), 64'd57);
    chk("held_out", cur_out, 64'h4008000000000000);
    // abort with reset in cycle 10 of DIV
    @(negedge clk);
    drive(1'b1, 64'h4018000000000000, 64'h4000000000000000);
    @(posedge clk);
    #1 drive(1'b0, 64'h4018000000000000, 64'h4000000000000000);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", 64'(cur_busy), 64'd0);
    chk("abort_out", cur_out, 64'd0);
    dn = int'(cur_done);
    repeat (60) begin
      @(posedge clk);
      #1 dn += int'(cur_done);
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    op("after_abort", 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 57);
    sel32 = 1'b1;
    op("s_div3_2", 64'h40400000, 64'h40000000, 64'h3FC00000, 28);
    op("s_one_zero", 64'h3F800000, 64'h00000000, 64'h7F800000, 1);
    op("s_zero_zero", 64'h00000000, 64'h00000000, 64'h7FC00000, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
